// File: rtl/proc_send_multi.sv
// proc_send_multi: round-robin send/ack handshake over N_CH channels.
// One channel is served at a time. A shared data word goes out with each
// request and advances by one after every completed handshake.
// Optional feature: define PROC_TIMEOUT_EN to abandon a request that is not
// acked within TMO_CYC cycles and record it in a sticky per-channel err flag.
//
// state | meaning
// IDLE  | no transfer; picks the next enabled channel at or above ptr
// REQ   | send[ch_sel] high, dado stable, waiting for ack[ch_sel]
// REL   | send low, waiting for ack[ch_sel] to drop before completing

module proc_send_multi #(
    parameter int N_CH    = 2,
    parameter int DATA_W  = 16,
    parameter int TMO_CYC = 64,
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   en,
    input  logic [N_CH-1:0]   ack,
    output logic [N_CH-1:0]   send,
    output logic [DATA_W-1:0] dado,
    output logic [CH_W-1:0]   ch_sel,
    output logic [N_CH-1:0]   err
);

    typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

    state_t            state_q, state_d;
    logic [N_CH-1:0]   send_q, send_d;
    logic [DATA_W-1:0] dado_q, dado_d;
    logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;

    logic              found;
    logic [CH_W-1:0]   pick;
    int                idx;
    logic              ack_sel;
    logic [CH_W-1:0]   ptr_next;

`ifdef PROC_TIMEOUT_EN
    localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [N_CH-1:0]   err_q, err_d;
    logic              tmo_hit;

    assign tmo_hit = (tmo_q == TW'(TMO_CYC - 1));
`endif

    // Round-robin search: first enabled channel at or above ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < N_CH; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!found && en[idx]) begin
                found = 1'b1;
                pick  = CH_W'(idx);
            end
        end
    end

    // Only the served channel's ack matters; next ptr is one past it.
    assign ack_sel  = ack[ch_sel_q];
    assign ptr_next = (int'(ch_sel_q) == N_CH - 1) ? '0 : ch_sel_q + CH_W'(1);

    // Next-state and next-output logic for the handshake FSM.
    always_comb begin
        state_d  = state_q;
        send_d   = send_q;
        dado_d   = dado_q;
        ch_sel_d = ch_sel_q;
        ptr_d    = ptr_q;
`ifdef PROC_TIMEOUT_EN
        tmo_d    = tmo_q;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    ch_sel_d     = pick;
                    send_d       = '0;
                    send_d[pick] = 1'b1;
                    state_d      = REQ;
`ifdef PROC_TIMEOUT_EN
                    tmo_d        = '0;
`endif
                end
            end
            REQ: begin
                if (ack_sel) begin
                    send_d  = '0;
                    state_d = REL;
                end
`ifdef PROC_TIMEOUT_EN
                else if (tmo_hit) begin
                    // Abandon without advancing dado so the word is re-offered.
                    send_d          = '0;
                    err_d[ch_sel_q] = 1'b1;
                    ptr_d           = ptr_next;
                    state_d         = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
`endif
            end
            REL: begin
                if (!ack_sel) begin
                    dado_d  = dado_q + DATA_W'(1);
                    ptr_d   = ptr_next;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops send immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            send_q   <= '0;
            dado_q   <= '0;
            ch_sel_q <= '0;
            ptr_q    <= '0;
`ifdef PROC_TIMEOUT_EN
            tmo_q    <= '0;
            err_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            send_q   <= send_d;
            dado_q   <= dado_d;
            ch_sel_q <= ch_sel_d;
            ptr_q    <= ptr_d;
`ifdef PROC_TIMEOUT_EN
            tmo_q    <= tmo_d;
            err_q    <= err_d;
`endif
        end
    end

    assign send   = send_q;
    assign dado   = dado_q;
    assign ch_sel = ch_sel_q;
`ifdef PROC_TIMEOUT_EN
    assign err    = err_q;
`else
    assign err    = '0;
`endif

endmodule

// File: tb/tb_proc_send_multi.sv
// Testbench for proc_send_multi (default build, timeout feature off).
// dut_a: N_CH=2, DATA_W=16. dut_b: N_CH=4, DATA_W=4 for skip, wrap and
// randomized transfers against a round-robin reference model.

module tb_proc_send_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [1:0]  en_a = '0, ack_a = '0, send_a, err_a;
    logic [15:0] dado_a;
    logic [0:0]  ch_sel_a;

    logic [3:0]  en_b = '0, ack_b = '0, send_b, err_b;
    logic [3:0]  dado_b;
    logic [1:0]  ch_sel_b;

    int n_tests = 0;
    int n_fail  = 0;

    int m_ptr  = 0;
    int m_dado = 0;

    always #5 clk = ~clk;

    proc_send_multi #(.N_CH(2), .DATA_W(16)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .ack(ack_a),
        .send(send_a), .dado(dado_a), .ch_sel(ch_sel_a), .err(err_a)
    );

    proc_send_multi #(.N_CH(4), .DATA_W(4)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .ack(ack_b),
        .send(send_b), .dado(dado_b), .ch_sel(ch_sel_b), .err(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: first enabled channel at or above p, wrapping modulo 4.
    function automatic int m_pick(input logic [3:0] e, input int p);
        for (int i = 0; i < 4; i++)
            if (e[(p + i) % 4]) return (p + i) % 4;
        return -1;
    endfunction

    // One full transfer on dut_b, checked against the model at every step.
    task automatic xfer_b(input logic [3:0] en_v, input logic [3:0] noise,
                          input int delay, input bit pre, input bit drop_en,
                          input int rel_hold);
        int ch;
        int c;
        logic [3:0] sel;
        ch    = m_pick(en_v, m_ptr);
        sel   = 4'b0001 << ch;
        en_b  = en_v;
        ack_b = (noise & ~sel) | (pre ? sel : 4'b0000);
        c = 0;
        do begin
            step();
            c++;
        end while (send_b == 4'b0000 && c < 10);
        chk("b_req_latency", c, 1);
        chk("b_req_send", send_b, sel);
        chk("b_req_ch_sel", ch_sel_b, ch);
        chk("b_req_dado", dado_b, m_dado);
        if (drop_en) en_b = 4'b0000;
        if (!pre) begin
            repeat (delay) begin
                step();
                chk("b_hold_send", send_b, sel);
                chk("b_hold_dado", dado_b, m_dado);
            end
            ack_b[ch] = 1'b1;
        end
        step();
        chk("b_rel_send", send_b, 4'b0000);
        repeat (rel_hold) begin
            step();
            chk("b_rel_hold_send", send_b, 4'b0000);
            chk("b_rel_hold_dado", dado_b, m_dado);
        end
        ack_b[ch] = 1'b0;
        step();
        m_dado = (m_dado + 1) % 16;
        m_ptr  = (ch + 1) % 4;
        chk("b_done_dado", dado_b, m_dado);
        chk("b_done_send", send_b, 4'b0000);
    endtask

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        // Reset state
        repeat (3) step();
        chk("rst_send_a", send_a, 2'b00);
        chk("rst_dado_a", dado_a, 16'h0);
        chk("rst_ch_sel_a", ch_sel_a, 1'b0);
        chk("rst_err_a", err_a, 2'b00);
        chk("rst_send_b", send_b, 4'b0000);
        chk("rst_dado_b", dado_b, 4'h0);
        chk("rst_err_b", err_b, 4'b0000);

        // Basic alternating transfers on dut_a, ack one cycle after request
        en_a = 2'b11;
        rst  = 1'b1;
        #1;
        chk("a_no_start_before_edge", send_a, 2'b00);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            if (k == 0) begin
                chk("a_first_req", send_a, 2'b01);
            end else begin
                c = 0;
                do begin
                    step();
                    c++;
                end while (send_a == 2'b00 && c < 10);
                chk("a_req_latency", c, 1);
            end
            chk("a_send", send_a, (k % 2) ? 2'b10 : 2'b01);
            chk("a_ch_sel", ch_sel_a, k % 2);
            chk("a_dado_at_req", dado_a, k);
            ack_a[k % 2] = 1'b1;
            step();
            chk("a_rel_send", send_a, 2'b00);
            ack_a = 2'b00;
            step();
            chk("a_done_dado", dado_a, k + 1);
        end

        // No timeout in default build: request held indefinitely
        en_a = 2'b01;
        c = 0;
        do begin
            step();
            c++;
        end while (send_a == 2'b00 && c < 10);
        chk("a_hold_start", send_a, 2'b01);
        repeat (200) begin
            step();
            chk("a_hold_send", send_a, 2'b01);
        end
        chk("a_hold_err", err_a, 2'b00);
        chk("a_hold_dado", dado_a, 16'd4);
        ack_a = 2'b01;
        step();
        en_a  = 2'b00;
        ack_a = 2'b00;
        step();
        chk("a_hold_release_dado", dado_a, 16'd5);

        // Skip disabled channels on dut_b, noise acks on ch0/ch2
        for (int k = 0; k < 4; k++) xfer_b(4'b1010, 4'b0101, 1, 1'b0, 1'b0, 0);

        // Randomized transfers; crosses the 4-bit dado wrap
        for (int k = 0; k < 24; k++)
            xfer_b(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        chk("b_err_after_random", err_b, 4'b0000);

        // Mid-operation reset while in REQ
        en_b  = 4'b0100;
        ack_b = 4'b0000;
        c = 0;
        do begin
            step();
            c++;
        end while (send_b == 4'b0000 && c < 10);
        chk("b_pre_rst_send", send_b, 4'b0100);
        step();
        rst = 1'b0;
        #1;
        chk("b_midrst_send", send_b, 4'b0000);
        chk("b_midrst_dado", dado_b, 4'h0);
        chk("b_midrst_ch_sel", ch_sel_b, 2'd0);
        @(negedge clk);
        en_b = 4'b1111;
        rst  = 1'b1;
        #1;
        chk("b_post_rst_idle", send_b, 4'b0000);
        @(negedge clk);
        m_ptr  = 0;
        m_dado = 0;
        // en is already set; first edge after release must start ch0
        chk("b_post_rst_first_send", send_b, 4'b0001);
        chk("b_post_rst_dado", dado_b, 4'h0);
        ack_b[0] = 1'b1;
        step();
        ack_b[0] = 1'b0;
        step();
        m_dado = 1;
        m_ptr  = 1;
        chk("b_post_rst_done_dado", dado_b, 4'h1);
        for (int k = 0; k < 6; k++)
            xfer_b(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        chk("b_err_final", err_b, 4'b0000);
        chk("a_err_final", err_a, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
